// File: rtl/imem_loader.sv
// Boot loader: assembles a big-endian byte stream into 32-bit words, writes them
// to instruction memory from address 0, then hands the address port to the PC.
module imem_loader #(
  parameter int unsigned DEPTH    = 256,
  parameter logic [31:0] END_WORD = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic [31:0] pc_in,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        load_done,
  output logic        load_error,
  output logic        pipe_run,
  output logic [31:0] word_count
);

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERROR} state_t;

  state_t      state;
  logic [1:0]  byte_cnt;
  logic [23:0] shreg;

  // The pipeline owns the address port once the program is loaded.
  assign mem_addr = (state == DONE) ? pc_in : word_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      byte_cnt   <= 2'd0;
      shreg      <= 24'd0;
      mem_wr     <= 1'b0;
      mem_wdata  <= 32'd0;
      word_count <= 32'd0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
      pipe_run   <= 1'b0;
    end else begin
      mem_wr <= 1'b0;
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state      <= LOAD;
            byte_cnt   <= 2'd0;
            shreg      <= 24'd0;
            word_count <= 32'd0;
            load_done  <= 1'b0;
            load_error <= 1'b0;
            pipe_run   <= 1'b0;
          end
        end
        LOAD: begin
          // Write cycle: commit the count and stop on the end marker.
          if (mem_wr) begin
            word_count <= word_count + 32'd1;
            if (mem_wdata == END_WORD) begin
              state     <= DONE;
              load_done <= 1'b1;
              pipe_run  <= 1'b1;
            end
          end
          if (rx_valid) begin
            shreg    <= {shreg[15:0], rx_data};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              if (word_count == DEPTH_W) begin
                state      <= ERROR;
                load_error <= 1'b1;
              end else begin
                mem_wdata <= {shreg, rx_data};
                mem_wr    <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
